sigma_avg_uart_tx: RTL and testbench

//  Downstream stage of the 16-sample sigma accumulator. Captures each 12-bit
//  two's-complement block sum on its sync pulse and forms the rounded mean (sum/16).

---
 rtl/sigma_avg_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_sigma_avg_uart_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_avg_uart_tx.sv
// Rounded mean of a 16-sample block sum, converted to 8-bit sign-magnitude,
// presented on a parallel port and buffered into a small FIFO feeding an 8N1 transmitter.
module sigma_avg_uart_tx #(
    parameter int unsigned SUM_W    = 12,
    parameter int unsigned BAUD_DIV = 16,
    parameter int unsigned FIFO_AW  = 2
) (
    input  logic               clk,
    input  logic               res,
    input  logic [SUM_W-1:0]   sum_in,
    input  logic               syn_in,
    output logic [7:0]         avg_out,
    output logic               avg_vld,
    output logic               ser_out,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic               ovf
);

    localparam int unsigned DEPTH  = 1 << FIFO_AW;
    localparam int unsigned CNT_W  = FIFO_AW + 1;
    localparam int unsigned BCNT_W = $clog2(BAUD_DIV);
    localparam int unsigned EXT_W  = SUM_W + 1;

    localparam logic signed [EXT_W-1:0] POS_LIM = EXT_W'(127);
    localparam logic signed [EXT_W-1:0] NEG_LIM = -POS_LIM;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_n;
    logic [BCNT_W-1:0]   bcnt, bcnt_n;
    logic [2:0]          bit_cnt, bit_n;
    logic [7:0]          shift, shift_n;
    logic                ser_n, busy_n;

    logic signed [EXT_W-1:0] t, m, m_sat;
    logic [7:0]              result;

    logic                syn_d;
    logic                capture, pop, full, push_ok, baud_end;
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;

    // Round-half-up mean, saturated to +/-127, then sign-magnitude
    always_comb begin
        t      = $signed({sum_in[SUM_W-1], sum_in}) + EXT_W'(8);
        m      = t >>> 4;
        m_sat  = m;
        if (m > POS_LIM) begin
            m_sat = POS_LIM;
        end else if (m < NEG_LIM) begin
            m_sat = NEG_LIM;
        end
        result = m_sat[EXT_W-1] ? {1'b1, 7'(-m_sat)} : {1'b0, 7'(m_sat)};
    end

    assign capture = syn_in & ~syn_d;
    assign full    = (fifo_cnt == CNT_W'(DEPTH));
    assign push_ok = capture & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= result;
        end
    end

    // Capture, parallel port and FIFO bookkeeping
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            syn_d    <= 1'b0;
            avg_out  <= 8'h00;
            avg_vld  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            syn_d   <= syn_in;
            avg_vld <= capture;
            if (capture) begin
                avg_out <= result;
            end
            if (capture && !push_ok) begin
                ovf <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Transmitter state register
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= IDLE;
            bcnt    <= '0;
            bit_cnt <= '0;
            shift   <= 8'h00;
            ser_out <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_n;
            bcnt    <= bcnt_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            ser_out <= ser_n;
            tx_busy <= busy_n;
        end
    end

    assign baud_end = (bcnt == BCNT_W'(BAUD_DIV - 1));

    // Next line level is computed here so ser_out leaves a flop
    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        ser_n   = ser_out;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                bcnt_n = '0;
                ser_n  = 1'b1;
                if (fifo_cnt != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                    ser_n   = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    bcnt_n  = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                    ser_n   = shift[0];
                end else begin
                    bcnt_n = bcnt + BCNT_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    bcnt_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                        ser_n   = 1'b1;
                    end else begin
                        shift_n = shift >> 1;
                        ser_n   = shift[1];
                        bit_n   = bit_cnt + 3'd1;
                    end
                end else begin
                    bcnt_n = bcnt + BCNT_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    bcnt_n = '0;
                    if (fifo_cnt != '0) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                        ser_n   = 1'b0;
                    end else begin
                        state_n = IDLE;
                        ser_n   = 1'b1;
                    end
                end else begin
                    bcnt_n = bcnt + BCNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                ser_n   = 1'b1;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_sigma_avg_uart_tx.sv
// Scoreboard bench: expected means and serial bytes are queued at capture time
// and matched against the parallel strobe and a bit-centre serial decoder.
module tb_sigma_avg_uart_tx;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic [11:0] sum_in = '0;
    logic        syn_in = 1'b0;
    logic [7:0]  avg_out;
    logic        avg_vld;
    logic        ser_out;
    logic        tx_busy;
    logic [2:0]  fifo_cnt;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_avg = 0;
    int n_frames = 0;
    logic [7:0] exp_avg[$];
    logic [7:0] exp_ser[$];
    int         frame_starts[$];

    bit         mbusy = 1'b0;
    int         mcnt = 0;
    logic [7:0] mbyte = '0;

    sigma_avg_uart_tx dut (
        .clk      (clk),
        .res      (res),
        .sum_in   (sum_in),
        .syn_in   (syn_in),
        .avg_out  (avg_out),
        .avg_vld  (avg_vld),
        .ser_out  (ser_out),
        .tx_busy  (tx_busy),
        .fifo_cnt (fifo_cnt),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference: round half up by floor((s+8)/16), clamp, sign-magnitude
    function automatic logic [7:0] model(input int s);
        int t;
        int m;
        t = s + 8;
        if (t >= 0) m = t / 16;
        else        m = -((-t + 15) / 16);
        if (m > 127)  m = 127;
        if (m < -127) m = -127;
        return (m < 0) ? {1'b1, 7'(-m)} : {1'b0, 7'(m)};
    endfunction

    // Parallel-port scoreboard
    always @(negedge clk) begin
        cyc++;
        if (!res && avg_vld === 1'b1) begin
            n_avg++;
            check("avg_q_nonempty", int'(exp_avg.size() > 0), 1);
            if (exp_avg.size() > 0) check("avg_out", int'(avg_out), int'(exp_avg.pop_front()));
        end
    end

    // Serial decoder sampling each bit at its centre
    always @(negedge clk) begin
        if (res) begin
            mbusy = 1'b0;
        end else if (!mbusy) begin
            if (ser_out === 1'b0) begin
                mbusy = 1'b1;
                mcnt  = 0;
                frame_starts.push_back(cyc);
            end
        end else begin
            mcnt++;
            if (mcnt == BD / 2) begin
                check("start_bit", int'(ser_out), 0);
                check("busy_in_frame", int'(tx_busy), 1);
            end else if (mcnt > BD && mcnt < 9 * BD && (mcnt % BD) == BD / 2) begin
                mbyte[mcnt / BD - 1] = ser_out;
            end else if (mcnt == 9 * BD + BD / 2) begin
                check("stop_bit", int'(ser_out), 1);
                n_frames++;
                check("ser_q_nonempty", int'(exp_ser.size() > 0), 1);
                if (exp_ser.size() > 0) check("ser_byte", int'(mbyte), int'(exp_ser.pop_front()));
                mbusy = 1'b0;
            end
        end
    end

    task automatic capture(input int s, input bit to_ser);
        @(posedge clk);
        #1;
        sum_in = 12'(s);
        syn_in = 1'b1;
        exp_avg.push_back(model(s));
        if (to_ser) exp_ser.push_back(model(s));
        @(posedge clk);
        #1;
        syn_in = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!tx_busy && fifo_cnt == 3'd0 && !mbusy) done = 1'b1;
        end
        check("idle_reached", int'(done), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int f0, a0, s0;
        int vals[5] = '{-24, -25, 7, 8, -8};

        #1 res = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ser_out", int'(ser_out), 1);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_fifo_cnt", int'(fifo_cnt), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_avg_vld", int'(avg_vld), 0);
        check("rst_avg_out", int'(avg_out), 0);
        res = 1'b0;
        repeat (2) @(posedge clk);

        // Basic frame and first-frame latency
        a0 = n_avg;
        capture(16, 1'b1);
        check("t1_avg_vld", int'(avg_vld), 1);
        check("t1_avg_out", int'(avg_out), 8'h01);
        check("t1_cnt_after_push", int'(fifo_cnt), 1);
        check("t1_line_still_idle", int'(ser_out), 1);
        @(posedge clk);
        #1;
        check("t1_start_falls", int'(ser_out), 0);
        check("t1_busy", int'(tx_busy), 1);
        check("t1_popped", int'(fifo_cnt), 0);
        check("t1_vld_one_cycle", int'(avg_vld), 0);
        wait_idle();
        check("t1_one_pulse", n_avg - a0, 1);

        // Rounding and sign
        foreach (vals[i]) begin
            capture(vals[i], 1'b1);
            wait_idle();
        end

        // Saturation
        capture(2047, 1'b1);
        wait_idle();
        capture(-2048, 1'b1);
        wait_idle();
        check("t3_no_ovf", int'(ovf), 0);

        // Overflow: sixth capture dropped, five back-to-back frames
        f0 = n_frames;
        s0 = frame_starts.size();
        capture(100, 1'b1);  repeat (2) @(posedge clk);
        capture(200, 1'b1);  repeat (2) @(posedge clk);
        capture(-300, 1'b1); repeat (2) @(posedge clk);
        capture(400, 1'b1);  repeat (2) @(posedge clk);
        capture(-500, 1'b1);
        check("t4_full", int'(fifo_cnt), 4);
        check("t4_ovf_clear", int'(ovf), 0);
        repeat (2) @(posedge clk);
        capture(600, 1'b0);
        check("t4_ovf_set", int'(ovf), 1);
        check("t4_still_full", int'(fifo_cnt), 4);
        wait_idle();
        check("t4_frames", n_frames - f0, 5);
        if (frame_starts.size() >= s0 + 5)
            check("t4_back_to_back", frame_starts[s0 + 4] - frame_starts[s0], 4 * 10 * BD);
        check("t4_ovf_sticky", int'(ovf), 1);
        check("t4_cnt_zero", int'(fifo_cnt), 0);

        // Held-high sync gives a single capture
        f0 = n_frames;
        a0 = n_avg;
        @(posedge clk);
        #1;
        sum_in = 12'(-1000);
        syn_in = 1'b1;
        exp_avg.push_back(model(-1000));
        exp_ser.push_back(model(-1000));
        repeat (20) @(posedge clk);
        #1;
        syn_in = 1'b0;
        wait_idle();
        check("t5_one_pulse", n_avg - a0, 1);
        check("t5_one_frame", n_frames - f0, 1);

        // Reset in the middle of data bit 3
        capture(16, 1'b1);
        capture(32, 1'b1);
        capture(48, 1'b1);
        repeat (68) @(posedge clk);
        #1;
        check("t6_bit3_low", int'(ser_out), 0);
        res = 1'b1;
        #1;
        check("t6_ser_high", int'(ser_out), 1);
        check("t6_busy_low", int'(tx_busy), 0);
        check("t6_cnt_zero", int'(fifo_cnt), 0);
        check("t6_ovf_zero", int'(ovf), 0);
        exp_ser.delete();
        repeat (3) @(posedge clk);
        #1;
        res = 1'b0;
        f0 = n_frames;
        repeat (2) @(posedge clk);
        capture(-300, 1'b1);
        wait_idle();
        check("t6_clean_frame", n_frames - f0, 1);
        check("t6_avg_q_drained", exp_avg.size(), 0);
        check("t6_ser_q_drained", exp_ser.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
